// File: rtl/rpn_stack_ctrl.sv
// Parametrised RPN operand stack: one encoded op per cycle, sticky overflow/underflow flags.
// Optional registered peek port enabled by defining STACK_PEEK_EN.
module rpn_stack_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   value,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   top,
  output logic [DATA_W-1:0]   next,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
`ifdef STACK_PEEK_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [DATA_W-1:0]        peek_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CFULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_PUSH      = 3'b001,
    OP_POP       = 3'b010,
    OP_WRITE     = 3'b011,
    OP_POP_WRITE = 3'b100,
    OP_SWAP      = 3'b101,
    OP_DUP       = 3'b110,
    OP_CLEAR     = 3'b111
  } op_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, udf_q;

  op_t               op_e;
  logic              is_empty, is_full, lt2;
  logic [AW-1:0]     push_idx, top_idx, next_idx;
  logic [DATA_W-1:0] top_word, next_word;

  logic              wa_en, wb_en;
  logic [AW-1:0]     wa_addr, wb_addr;
  logic [DATA_W-1:0] wa_data, wb_data;
  logic              ovf_set, udf_set;

  assign op_e     = op_t'(op);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CFULL);
  assign lt2      = (count_q < TWO);

  // push_idx only used when not full, so dropping the top count bit is safe
  assign push_idx = count_q[AW-1:0];
  assign top_idx  = AW'(count_q - ONE);
  assign next_idx = AW'(count_q - TWO);

  assign top_word  = is_empty ? '0 : mem[top_idx];
  assign next_word = lt2      ? '0 : mem[next_idx];

  always_comb begin
    count_d = count_q;
    wa_en   = 1'b0;
    wa_addr = '0;
    wa_data = '0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    case (op_e)
      OP_PUSH: begin
        if (is_full) ovf_set = 1'b1;
        else begin
          wa_en   = 1'b1;
          wa_addr = push_idx;
          wa_data = value;
          count_d = count_q + ONE;
        end
      end
      OP_POP: begin
        if (is_empty) udf_set = 1'b1;
        else count_d = count_q - ONE;
      end
      OP_WRITE: begin
        if (is_empty) udf_set = 1'b1;
        else begin
          wa_en   = 1'b1;
          wa_addr = top_idx;
          wa_data = value;
        end
      end
      OP_POP_WRITE: begin
        if (lt2) udf_set = 1'b1;
        else begin
          wa_en   = 1'b1;
          wa_addr = next_idx;
          wa_data = value;
          count_d = count_q - ONE;
        end
      end
      OP_SWAP: begin
        if (lt2) udf_set = 1'b1;
        else begin
          wa_en   = 1'b1;
          wa_addr = top_idx;
          wa_data = next_word;
          wb_en   = 1'b1;
          wb_addr = next_idx;
          wb_data = top_word;
        end
      end
      OP_DUP: begin
        // empty is checked first so an empty DUP reports underflow only
        if (is_empty) udf_set = 1'b1;
        else if (is_full) ovf_set = 1'b1;
        else begin
          wa_en   = 1'b1;
          wa_addr = push_idx;
          wa_data = top_word;
          count_d = count_q + ONE;
        end
      end
      OP_CLEAR: count_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wa_en) mem[wa_addr] <= wa_data;
      if (wb_en) mem[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_set | (ovf_q & ~err_clr);
      udf_q   <= udf_set | (udf_q & ~err_clr);
    end
  end

  assign top       = top_word;
  assign next      = next_word;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

`ifdef STACK_PEEK_EN
  logic [CNT_W-1:0] peek_cnt;
  logic [AW-1:0]    peek_addr;

  assign peek_cnt  = CNT_W'(peek_idx);
  assign peek_addr = AW'(count_q - ONE - peek_cnt);

  always_ff @(posedge clock) begin
    if (reset) peek_data <= '0;
    else       peek_data <= (peek_cnt < count_q) ? mem[peek_addr] : '0;
  end
`endif

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Randomised self-checking bench for rpn_stack_ctrl (DEPTH=4, DATA_W=8) against a queue model.
module tb_rpn_stack_ctrl;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] value = '0;
  logic          err_clr = 1'b0;
  logic [1:0]    peek_idx = 2'd0;
  logic [DW-1:0] top, next;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;
`ifdef STACK_PEEK_EN
  logic [DW-1:0] peek_data;
`endif

  rpn_stack_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clock(clock), .reset(reset), .op(op), .value(value), .err_clr(err_clr),
    .top(top), .next(next), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
`ifdef STACK_PEEK_EN
    , .peek_idx(peek_idx), .peek_data(peek_data)
`endif
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the stack as a queue, back = top of stack.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0, m_udf = 1'b0;
  logic [DW-1:0] m_peek = '0;

  function automatic logic [DW-1:0] m_top();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [DW-1:0] m_next();
    return (mq.size() > 1) ? mq[mq.size()-2] : '0;
  endfunction

  task automatic step(input logic rst, input logic [2:0] o, input logic [DW-1:0] v,
                      input logic clr, input logic [1:0] pidx);
    bit e_ovf, e_udf;
    logic [DW-1:0] t;
    int n;
    @(negedge clock);
    reset = rst; op = o; value = v; err_clr = clr; peek_idx = pidx;
    n = mq.size();
    m_peek = (int'(pidx) < n) ? mq[n-1-int'(pidx)] : '0;
    e_ovf = 1'b0; e_udf = 1'b0;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_peek = '0;
    end else begin
      case (o)
        3'd1: if (n == DP) e_ovf = 1'b1; else mq.push_back(v);
        3'd2: if (n == 0) e_udf = 1'b1; else void'(mq.pop_back());
        3'd3: if (n == 0) e_udf = 1'b1; else mq[n-1] = v;
        3'd4: if (n < 2) e_udf = 1'b1; else begin void'(mq.pop_back()); mq[n-2] = v; end
        3'd5: if (n < 2) e_udf = 1'b1; else begin t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t; end
        3'd6: if (n == 0) e_udf = 1'b1; else if (n == DP) e_ovf = 1'b1; else mq.push_back(mq[n-1]);
        3'd7: mq.delete();
        default: ;
      endcase
      m_ovf = e_ovf | (m_ovf & ~clr);
      m_udf = e_udf | (m_udf & ~clr);
    end
    @(posedge clock);
    #1;
    check("top", top, m_top());
    check("next", next, m_next());
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DP);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
`ifdef STACK_PEEK_EN
    check("peek_data", peek_data, m_peek);
`endif
  endtask

  initial begin
    step(1, 3'd0, 8'd0, 0, 0);
    step(1, 3'd0, 8'd0, 0, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);

    step(0, 3'd1, 8'd5, 0, 0);
    step(0, 3'd1, 8'd7, 0, 0);
    check("push_top", top, 7);
    check("push_next", next, 5);
    step(0, 3'd5, 8'd0, 0, 0);
    check("swap_top", top, 5);
    step(0, 3'd4, 8'd12, 0, 0);
    check("popwr_top", top, 12);
    step(0, 3'd2, 8'd0, 0, 0);
    step(0, 3'd2, 8'd0, 0, 0);
    check("pop_empty_udf", underflow, 1);
    step(0, 3'd0, 8'd0, 1, 0);

    for (int i = 1; i <= 4; i++) step(0, 3'd1, 8'(i), 0, 0);
    step(0, 3'd6, 8'd0, 0, 0);
    check("dup_full_ovf", overflow, 1);
    check("dup_full_top", top, 4);
    step(0, 3'd0, 8'd0, 1, 0);
    step(0, 3'd1, 8'd9, 1, 0);
    check("clr_vs_set", overflow, 1);
    step(0, 3'd7, 8'd0, 0, 0);

    step(0, 3'd0, 8'd0, 1, 0);
    step(0, 3'd1, 8'd3, 0, 0);
    step(0, 3'd3, 8'd9, 0, 0);
    step(0, 3'd6, 8'd0, 0, 0);
    check("dup_next", next, 9);
    step(0, 3'd7, 8'd0, 0, 0);
    step(0, 3'd7, 8'd0, 0, 0);
    step(0, 3'd6, 8'd0, 0, 0);

    for (int i = 1; i <= 3; i++) step(0, 3'd1, 8'(i), 0, 0);
    step(1, 3'd1, 8'd6, 0, 0);
    check("rst_wins_count", count, 0);

    for (int i = 1; i <= 3; i++) step(0, 3'd1, 8'(i), 0, 0);
    step(0, 3'd0, 8'd0, 0, 2'd2);
    step(0, 3'd0, 8'd0, 0, 2'd3);
    step(0, 3'd0, 8'd0, 0, 2'd0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
